// File: rtl/seq_multiplier_32bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_32bit (with helper adder_32bit)
// Purpose  : Multi-cycle shift-and-add multiplier for MULT/MULTU. Operand
//            magnitudes are multiplied over WIDTH cycles through a single
//            ripple adder; the sign is applied once at the end.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            start           - request a multiply (sampled only in IDLE)
//            is_signed       - 1 = two's complement, 0 = unsigned
//            a, b            - multiplicand / multiplier
//            busy            - high while computing (CALC or SIGN)
//            done            - one-cycle completion pulse
//            hi, lo          - upper / lower halves of the 64-bit product
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder_32bit : combinational WIDTH-bit adder with carry in/out
// ----------------------------------------------------------------------------
module adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
endmodule

// ----------------------------------------------------------------------------
// seq_multiplier_32bit
// ----------------------------------------------------------------------------
module seq_multiplier_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_neg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [2*WIDTH-1:0] w_acc;

  // Magnitudes: the most-negative value maps onto itself, which is correct
  // when the result is treated as an unsigned WIDTH-bit magnitude.
  assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_acc    = {r_acc_hi, r_acc_lo};

  adder_32bit #(.WIDTH(WIDTH)) u_adder (
    .a         (r_acc_hi),
    .b         (w_addend),
    .carry_in  (1'b0),
    .sum       (w_sum),
    .carry_out (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // The adder carry becomes the new top bit as the 64-bit
          // accumulator shifts right by one.
          r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
          r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last_iter) begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (r_neg) begin
            {r_hi, r_lo} <= ~w_acc + 1'b1;
          end else begin
            {r_hi, r_lo} <= w_acc;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == S_CALC) || (r_state == S_SIGN);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_32bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier_32bit
// Purpose  : Self-checking bench for seq_multiplier_32bit. Expected products
//            come from plain 64-bit arithmetic and are queued at issue time;
//            a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  seq_multiplier_32bit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          e0;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   e0 = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact product of the operands, interpreted per mode.
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Monitor: compare every completed result with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && prev_done) begin
        chk("done_width", 64'd1, 64'd0);
      end
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", {hi, lo}, e.prod);
          chk("latency", 64'(cyc - e.e0), 64'd33);
        end
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(negedge clk);
    is_signed = s;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    e.prod = ref_mul(s, x, y);
    e.e0 = e0;
    q.push_back(e);
    // Operands must not matter after acceptance.
    a = $urandom;
    b = $urandom;
    is_signed = ~s;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic run(input logic s, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    start_op(s, x, y);
    wait_empty();
  endtask

  initial begin
    int nb;
    int dc;
    int loops;
    logic [31:0] corner [6];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    corner[5] = 32'hFFFF_FFFE;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;

    // 5*7 with busy-duration check
    wait_idle();
    start_op(1'b0, 32'd5, 32'd7);
    nb = 0;
    loops = 0;
    while (loops < 60) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      loops++;
    end
    chk("busy_cycles", 64'(nb), 64'd33);
    wait_empty();
    chk("hilo_5x7", {hi, lo}, 64'h0000_0000_0000_0023);

    // Directed sign cases
    run(1'b1, 32'hFFFF_FFFD, 32'd7);
    chk("hilo_s_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(1'b0, 32'hFFFF_FFFD, 32'd7);
    chk("hilo_u_m3x7", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("hilo_u_ff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("hilo_s_ff", {hi, lo}, 64'h0000_0000_0000_0001);
    run(1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("hilo_s_min2", {hi, lo}, 64'h4000_0000_0000_0000);
    run(1'b1, 32'h8000_0000, 32'd1);
    chk("hilo_s_minx1", {hi, lo}, 64'hFFFF_FFFF_8000_0000);

    // Start during CALC is ignored
    wait_idle();
    start_op(1'b0, 32'd3, 32'd4);
    dc = done_cnt;
    loops = 0;
    while (cyc < e0 + 9 && loops < 20) begin
      @(negedge clk);
      loops++;
    end
    is_signed = 1'b0;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty();
    repeat (40) @(negedge clk);
    chk("ignored_start_dones", 64'(done_cnt - dc), 64'd1);
    chk("idle_hold", {hi, lo}, 64'd12);

    // Reset mid-operation; hi/lo hold the previous result during CALC
    wait_idle();
    start_op(1'b0, 32'd6, 32'd6);
    repeat (5) @(negedge clk);
    chk("calc_hold", {hi, lo}, 64'd12);
    loops = 0;
    while (cyc < e0 + 15 && loops < 20) begin
      @(negedge clk);
      loops++;
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_reset", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 32'd2, 32'd3);
    chk("after_reset_2x3", {hi, lo}, 64'd6);

    // Randomized operations with corner-value bias
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      logic        s;
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      s = 1'($urandom_range(0, 1));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(s, x, y);
      wait_empty();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
